// File: rtl/led_frame_feeder.sv
// Brightness-word FIFO feeding an LED PWM controller: one word is popped per frame,
// with a registered frame-start pulse and a sticky underflow flag.
module led_frame_feeder #(
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned FRAME_CYCLES = 4096,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          globalReset_n,
    input  logic [DATA_WIDTH-1:0]         inData,
    input  logic                          inValid,
    output logic                          inReady,
    output logic [DATA_WIDTH-1:0]         LEDFrameData,
    output logic                          frameReset,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic                          underflow
);

    localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CNT_W-1:0]      frame_cnt;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_next;
    logic                  boundary;
    logic                  push;
    logic                  pop;

    always_comb begin
        boundary   = (frame_cnt == CNT_LAST);
        push       = inValid && inReady;
        pop        = boundary && (fifoLevel != '0);
        level_next = fifoLevel;
        if (push && !pop)
            level_next = fifoLevel + LVL_W'(1);
        else if (pop && !push)
            level_next = fifoLevel - LVL_W'(1);
    end

    // Storage is not reset; only pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= inData;
    end

    // inReady is registered from the next level, so it never depends on inValid
    // and is held low while reset is applied.
    always_ff @(posedge clk) begin
        if (!globalReset_n) begin
            frame_cnt    <= CNT_LAST;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifoLevel    <= '0;
            LEDFrameData <= '0;
            underflow    <= 1'b0;
            frameReset   <= 1'b1;
            inReady      <= 1'b0;
        end else begin
            frame_cnt  <= boundary ? '0 : frame_cnt + CNT_W'(1);
            frameReset <= boundary;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                LEDFrameData <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + PTR_W'(1);
            end
            if (boundary && fifoLevel == '0)
                underflow <= 1'b1;
            fifoLevel <= level_next;
            inReady   <= (level_next < LVL_FULL);
        end
    end

endmodule
